sfifo_gen: RTL and testbench

- Parametrised synchronous FIFO and the next generation of the team's 8x64 sfifo.
- Configurable data width and depth, programmable almost-full/almost-empty thresholds, exported occupancy count, sticky error flags with explicit clear.
- Correct simultaneous read/write at full and at empty.
- Sits between single-clock producer/consumer blocks as the standard buffering primitive.

---
 rtl/sfifo_pkg.sv | 31 +++
 rtl/sfifo_gen_if.sv | 48 ++++
 rtl/sfifo_mem.sv | 55 +++++
 rtl/sfifo_gen.sv | 157 +++++++++++++++
 tb/tb_sfifo_gen.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/sfifo_pkg.sv
// ----------------------------------------------------------------------------
// sfifo_pkg
// Shared constants and elaboration-time helpers for the sfifo_gen family.
//   DEF_DATA_W / DEF_DEPTH : default word width and entry count
//   clog2()                : ceiling log2, used to size the pointers (AW)
//   cnt_width()            : width of an occupancy count that can hold DEPTH
// ----------------------------------------------------------------------------
package sfifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 64;

    // Ceiling log2; clog2(1) = 0, clog2(64) = 6, clog2(65) = 7.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // The count has to represent DEPTH itself (full), so one bit more than AW.
    function automatic int cnt_width(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sfifo_gen_if.sv
// ----------------------------------------------------------------------------
// sfifo_gen_if
// Producer/consumer-facing bus of sfifo_gen.
//   w_en, din          : write request and data
//   r_en               : read request
//   clr_err            : pulse that clears the sticky error flags
//   dout               : registered read data
//   full, empty        : occupancy == DEPTH / == 0
//   almost_full/empty  : threshold flags
//   word_cnt           : occupancy 0..DEPTH
//   overflow/underflow : sticky rejected-write / rejected-read flags
// Modports: master = the block using the FIFO, slave = the FIFO itself.
// ----------------------------------------------------------------------------
interface sfifo_gen_if
    import sfifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) ();

    localparam int CW = cnt_width(DEPTH);

    logic              w_en;
    logic [DATA_W-1:0] din;
    logic              r_en;
    logic              clr_err;
    logic [DATA_W-1:0] dout;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CW-1:0]     word_cnt;
    logic              overflow;
    logic              underflow;

    modport master (
        output w_en, din, r_en, clr_err,
        input  dout, full, empty, almost_full, almost_empty,
               word_cnt, overflow, underflow
    );

    modport slave (
        input  w_en, din, r_en, clr_err,
        output dout, full, empty, almost_full, almost_empty,
               word_cnt, overflow, underflow
    );

endinterface

// File: rtl/sfifo_mem.sv
// ----------------------------------------------------------------------------
// sfifo_mem
// Simple dual-port RAM, DEPTH x DATA_W, one synchronous write port and one
// synchronous read port with a registered output.
//   clk      : clock
//   rst      : synchronous active-high reset (read register only)
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_re     : read enable
//   i_raddr  : read address
//   o_rdata  : read data, updated the edge after i_re, held while i_re = 0
// A read and a write to the same address in one cycle returns the old word.
// ----------------------------------------------------------------------------
module sfifo_mem
    import sfifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AW     = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // NOTE: the array has no reset so it maps onto block RAM; stale contents
    // are never observable because the pointers and count are reset instead.
    always_ff @(posedge clk) begin
        if (i_we) begin
            // NOTE: non-blocking here is what makes a same-address read in this
            // cycle see the previous word rather than the one being written.
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sfifo_gen.sv
// ----------------------------------------------------------------------------
// sfifo_gen
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// thresholds, exported occupancy and sticky overflow/underflow flags.
//   clk : clock, all logic on the rising edge
//   rst : synchronous active-high reset
//   bus : sfifo_gen_if.slave (requests in, data/status out)
// Parameters: DATA_W, DEPTH (power of two, >= 4), AF_THRESH (1..DEPTH),
//             AE_THRESH (0..DEPTH-1).
// Build option: SFIFO_GEN_INFLOP_EN adds a register stage on w_en, r_en, din
// and clr_err; request-to-dout latency becomes 2 cycles.
// ----------------------------------------------------------------------------
module sfifo_gen
    import sfifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4
) (
    input  logic        clk,
    input  logic        rst,
    sfifo_gen_if.slave  bus
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    // ------------------------------------------------------------------
    // Request source: either the bus directly or a registered copy.
    // ------------------------------------------------------------------
    logic              w_w_en;
    logic              w_r_en;
    logic              w_clr_err;
    logic [DATA_W-1:0] w_din;

`ifdef SFIFO_GEN_INFLOP_EN
    logic              r_w_en_q;
    logic              r_r_en_q;
    logic              r_clr_err_q;
    logic [DATA_W-1:0] r_din_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_w_en_q    <= 1'b0;
            r_r_en_q    <= 1'b0;
            r_clr_err_q <= 1'b0;
            r_din_q     <= '0;
        end else begin
            r_w_en_q    <= bus.w_en;
            r_r_en_q    <= bus.r_en;
            r_clr_err_q <= bus.clr_err;
            r_din_q     <= bus.din;
        end
    end

    assign w_w_en    = r_w_en_q;
    assign w_r_en    = r_r_en_q;
    assign w_clr_err = r_clr_err_q;
    assign w_din     = r_din_q;
`else
    assign w_w_en    = bus.w_en;
    assign w_r_en    = bus.r_en;
    assign w_clr_err = bus.clr_err;
    assign w_din     = bus.din;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_word_cnt;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_full;
    logic          w_empty;
    logic          w_rd_acc;
    logic          w_wr_acc;

    assign w_full  = (r_word_cnt == CW'(DEPTH));
    assign w_empty = (r_word_cnt == '0);

    // A read frees a slot in the same edge, so a full FIFO can still take a
    // write when a read is accepted alongside it. No bypass at empty: the
    // read is rejected and the write lands normally.
    assign w_rd_acc = w_r_en & ~w_empty;
    assign w_wr_acc = w_w_en & (~w_full | w_rd_acc);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            // Pointers are exactly AW bits, so DEPTH-1 + 1 wraps to 0.
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_cnt <= '0;
        end else begin
            r_word_cnt <= r_word_cnt + CW'(w_wr_acc) - CW'(w_rd_acc);
        end
    end

    // Sticky errors; a fresh error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (w_w_en & ~w_wr_acc) | (r_overflow  & ~w_clr_err);
            r_underflow <= (w_r_en & ~w_rd_acc) | (r_underflow & ~w_clr_err);
        end
    end

    // ------------------------------------------------------------------
    // Storage; its registered read port is the FIFO's dout.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_rdata;

    sfifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_din),
        .i_re    (w_rd_acc),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    // ------------------------------------------------------------------
    // Outputs: all status decoded from the registered count only.
    // ------------------------------------------------------------------
    assign bus.dout         = w_rdata;
    assign bus.word_cnt     = r_word_cnt;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_word_cnt >= CW'(AF_THRESH));
    assign bus.almost_empty = (r_word_cnt <= CW'(AE_THRESH));
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_sfifo_gen.sv
// ----------------------------------------------------------------------------
// tb_sfifo_gen
// Directed bench for sfifo_gen at DATA_W=8, DEPTH=64, AF_THRESH=60,
// AE_THRESH=4. Each operation is presented for one cycle and its effect is
// checked once it has taken hold (one extra cycle with SFIFO_GEN_INFLOP_EN).
// ----------------------------------------------------------------------------
module tb_sfifo_gen;

    import sfifo_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 64;
    localparam int AF_TH  = 60;
    localparam int AE_TH  = 4;

`ifdef SFIFO_GEN_INFLOP_EN
    localparam int IN_LAT = 1;
`else
    localparam int IN_LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    sfifo_gen_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    sfifo_gen #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_TH),
        .AE_THRESH (AE_TH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one request for a single cycle, then idle until it has acted.
    task automatic apply(input logic w, input logic [7:0] d, input logic r, input logic c);
        bus.w_en    = w;
        bus.din     = d;
        bus.r_en    = r;
        bus.clr_err = c;
        @(posedge clk);
        #1;
        bus.w_en    = 1'b0;
        bus.din     = 8'h00;
        bus.r_en    = 1'b0;
        bus.clr_err = 1'b0;
        repeat (IN_LAT) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Expected flags follow from the expected count and the chosen thresholds.
    task automatic check_occ(input string tag, input int cnt);
        check({tag, "/word_cnt"},     32'(bus.word_cnt),     32'(cnt));
        check({tag, "/full"},         32'(bus.full),         32'(cnt == DEPTH));
        check({tag, "/empty"},        32'(bus.empty),        32'(cnt == 0));
        check({tag, "/almost_full"},  32'(bus.almost_full),  32'(cnt >= AF_TH));
        check({tag, "/almost_empty"}, 32'(bus.almost_empty), 32'(cnt <= AE_TH));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.w_en    = 1'b0;
        bus.din     = 8'h00;
        bus.r_en    = 1'b0;
        bus.clr_err = 1'b0;
        @(posedge clk);
        #1;

        // 1. Reset then idle.
        do_reset(2);
        check_occ("t1", 0);
        check("t1/dout",      32'(bus.dout),      32'h0);
        check("t1/overflow",  32'(bus.overflow),  32'h0);
        check("t1/underflow", 32'(bus.underflow), 32'h0);

        // 2. Fill 0x00..0x3F; almost_full from count 60, full at 64.
        for (int i = 0; i < DEPTH; i++) begin
            apply(1'b1, 8'(i), 1'b0, 1'b0);
            check_occ($sformatf("t2_fill%0d", i), i + 1);
        end

        // 3. Extra write at full is rejected and sets overflow; clr_err clears.
        apply(1'b1, 8'hAA, 1'b0, 1'b0);
        check("t3/overflow", 32'(bus.overflow), 32'h1);
        check_occ("t3", DEPTH);
        apply(1'b0, 8'h00, 1'b0, 1'b1);
        check("t3/overflow_clr", 32'(bus.overflow), 32'h0);

        // Drain: 0x00 first (0xAA was never stored), down to empty.
        for (int i = 0; i < DEPTH; i++) begin
            apply(1'b0, 8'h00, 1'b1, 1'b0);
            check($sformatf("t2_drain%0d/dout", i), 32'(bus.dout), 32'(i));
            check_occ($sformatf("t2_drain%0d", i), DEPTH - 1 - i);
        end
        check("t2/underflow", 32'(bus.underflow), 32'h0);

        // 4. Simultaneous read/write at empty.
        apply(1'b1, 8'h55, 1'b1, 1'b0);
        check_occ("t4", 1);
        check("t4/underflow", 32'(bus.underflow), 32'h1);
        check("t4/overflow",  32'(bus.overflow),  32'h0);
        check("t4/dout_hold", 32'(bus.dout),      32'h3F);
        apply(1'b0, 8'h00, 1'b1, 1'b0);
        check("t4/dout", 32'(bus.dout), 32'h55);
        check_occ("t4_rd", 0);
        // Rejected read in the clearing cycle: the error wins.
        apply(1'b0, 8'h00, 1'b1, 1'b1);
        check("t4/err_wins", 32'(bus.underflow), 32'h1);
        check("t4/dout_hold2", 32'(bus.dout), 32'h55);
        apply(1'b0, 8'h00, 1'b0, 1'b1);
        check("t4/underflow_clr", 32'(bus.underflow), 32'h0);

        // 5. Simultaneous at full; pointers start at 1 so they wrap past 63.
        for (int i = 0; i < DEPTH; i++) begin
            apply(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        end
        check_occ("t5_fill", DEPTH);
        apply(1'b1, 8'h77, 1'b1, 1'b0);
        check_occ("t5_rw", DEPTH);
        check("t5/overflow", 32'(bus.overflow), 32'h0);
        check("t5/dout",     32'(bus.dout),     32'h80);
        for (int i = 0; i < DEPTH - 1; i++) begin
            apply(1'b0, 8'h00, 1'b1, 1'b0);
            check($sformatf("t5_drain%0d/dout", i), 32'(bus.dout), 32'(8'h81 + i));
        end
        apply(1'b0, 8'h00, 1'b1, 1'b0);
        check("t5/last_dout", 32'(bus.dout), 32'h77);
        check_occ("t5_end", 0);

        // 6. Reset mid-operation with 10 entries and a sticky flag set.
        apply(1'b0, 8'h00, 1'b1, 1'b0);
        check("t6/underflow_pre", 32'(bus.underflow), 32'h1);
        for (int i = 0; i < 10; i++) begin
            apply(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        end
        check_occ("t6_pre", 10);
        bus.w_en = 1'b1;             // request during reset must be ignored
        bus.din  = 8'hEE;
        do_reset(1);
        bus.w_en = 1'b0;
        bus.din  = 8'h00;
        repeat (IN_LAT) begin
            @(posedge clk);
            #1;
        end
        check_occ("t6_rst", 0);
        check("t6/overflow",  32'(bus.overflow),  32'h0);
        check("t6/underflow", 32'(bus.underflow), 32'h0);
        check("t6/dout",      32'(bus.dout),      32'h0);
        apply(1'b1, 8'h3C, 1'b0, 1'b0);
        check_occ("t6_wr", 1);
        apply(1'b0, 8'h00, 1'b1, 1'b0);
        check("t6/dout_3c", 32'(bus.dout), 32'h3C);
        check_occ("t6_rd", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
